// File: rtl/lc3_mem_access_if.sv
// Bundle of the LC-3 memory-access stage: control from the address stage,
// results to writeback, and the request/ready data-memory port.
interface lc3_mem_access_if;
  // Control: START is sampled only while BUSY=0; DONE pulses for one cycle.
  logic        START;
  logic [15:0] IR;
  logic [15:0] EA;
  logic [15:0] SR_DATA;
  logic        BUSY;
  logic        DONE;
  logic [15:0] LOAD_DATA;
  logic        N;
  logic        Z;
  logic        P;
  // Memory port: a transfer completes on the rising edge where MEM_REQ=1 and
  // MEM_RDY=1. While MEM_REQ=1 and MEM_RDY=0, MEM_ADDR/MEM_WE/MEM_WDATA hold.
  // MEM_REQ may drop without a handshake only on reset.
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [15:0] MEM_ADDR;
  logic [15:0] MEM_WDATA;
  logic [15:0] MEM_RDATA;
  logic        MEM_RDY;
  logic [2:0]  dbg_state;

  modport slave (
    input  START, IR, EA, SR_DATA, MEM_RDATA, MEM_RDY,
    output BUSY, DONE, LOAD_DATA, N, Z, P,
           MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, dbg_state
  );

  modport master (
    output START, IR, EA, SR_DATA, MEM_RDATA, MEM_RDY,
    input  BUSY, DONE, LOAD_DATA, N, Z, P,
           MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, dbg_state
  );
endinterface

// File: rtl/lc3_mem_access.sv
// LC-3 memory-access stage: LD/LDI/LDR/ST/STI/STR/LEA over a request/ready
// port, with registered (Moore) outputs and N/Z/P generation for writeback.
module lc3_mem_access (
  input  logic             CLK,
  input  logic             RESET,
  lc3_mem_access_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IND_RD   = 3'd1,
    DATA_RD  = 3'd2,
    DATA_WR  = 3'd3,
    COMPLETE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] load_data_q, load_data_d;
  logic        n_q, n_d;
  logic        z_q, z_d;
  logic        p_q, p_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        cc_load;
  logic [15:0] cc_val;

  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    done_d      = 1'b0;
    load_data_d = load_data_q;
    n_d         = n_q;
    z_d         = z_q;
    p_d         = p_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cc_load     = 1'b0;
    cc_val      = 16'h0000;

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          case (bus.IR[15:12])
            4'b0010, 4'b0110: begin
              state_d    = DATA_RD;
              is_store_d = 1'b0;
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = bus.EA;
            end
            4'b1010: begin
              state_d    = IND_RD;
              is_store_d = 1'b0;
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = bus.EA;
            end
            // STI keeps its store data in the write-data register through the pointer read.
            4'b1011: begin
              state_d     = IND_RD;
              is_store_d  = 1'b1;
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b0;
              mem_addr_d  = bus.EA;
              mem_wdata_d = bus.SR_DATA;
            end
            4'b0011, 4'b0111: begin
              state_d     = DATA_WR;
              is_store_d  = 1'b1;
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = bus.EA;
              mem_wdata_d = bus.SR_DATA;
            end
            4'b1110: begin
              state_d = COMPLETE;
              done_d  = 1'b1;
              cc_load = 1'b1;
              cc_val  = bus.EA;
            end
            default: ;
          endcase
        end
      end
      IND_RD: begin
        if (bus.MEM_RDY) begin
          mem_addr_d = bus.MEM_RDATA;
          if (is_store_q) begin
            state_d  = DATA_WR;
            mem_we_d = 1'b1;
          end else begin
            state_d = DATA_RD;
          end
        end
      end
      DATA_RD: begin
        if (bus.MEM_RDY) begin
          state_d   = COMPLETE;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          cc_load   = 1'b1;
          cc_val    = bus.MEM_RDATA;
        end
      end
      DATA_WR: begin
        if (bus.MEM_RDY) begin
          state_d   = COMPLETE;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if (cc_load) begin
      load_data_d = cc_val;
      n_d         = cc_val[15];
      z_d         = (cc_val == 16'h0000);
      p_d         = !cc_val[15] && (cc_val != 16'h0000);
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      is_store_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_data_q <= 16'h0000;
      n_q         <= 1'b0;
      z_q         <= 1'b1;
      p_q         <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      load_data_q <= load_data_d;
      n_q         <= n_d;
      z_q         <= z_d;
      p_q         <= p_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.LOAD_DATA = load_data_q;
  assign bus.N         = n_q;
  assign bus.Z         = z_q;
  assign bus.P         = p_q;
  assign bus.MEM_REQ   = mem_req_q;
  assign bus.MEM_WE    = mem_we_q;
  assign bus.MEM_ADDR  = mem_addr_q;
  assign bus.MEM_WDATA = mem_wdata_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_lc3_mem_access.sv
// Bench for lc3_mem_access: memory responder with programmable wait states,
// access and result scoreboards, latency and robustness checks.
module tb_lc3_mem_access;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  lc3_mem_access_if bus();

  lc3_mem_access dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [logic [15:0]];
  logic [18:0] exp_q[$];     // {LOAD_DATA, N, Z, P}
  logic [32:0] acc_q[$];     // {we, addr, wdata-or-0}
  int          wait_n = 0;
  int          rsp_cnt = 0;
  logic        rsp_was_req = 1'b0;
  logic [32:0] held;
  logic [32:0] cur_acc;
  logic [32:0] exp_acc;
  logic [15:0] model_load;
  logic [2:0]  model_nzp;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if (v[15])        return 3'b100;
    if (v == 16'h0)   return 3'b010;
    return 3'b001;
  endfunction

  // Memory responder: drives MEM_RDY/MEM_RDATA on the falling edge.
  initial begin
    bus.MEM_RDY   = 1'b0;
    bus.MEM_RDATA = 16'h0000;
    forever begin
      @(negedge CLK);
      cur_acc = {bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WE ? bus.MEM_WDATA : 16'h0000};
      if (bus.MEM_RDY) rsp_cnt = 0;
      if (bus.MEM_REQ && !bus.MEM_RDY && rsp_was_req)
        check("addr_stable", cur_acc, held);
      rsp_was_req = bus.MEM_REQ;
      if (!bus.MEM_REQ) begin
        rsp_cnt     = 0;
        bus.MEM_RDY = 1'b0;
      end else if (rsp_cnt < wait_n) begin
        rsp_cnt++;
        bus.MEM_RDY = 1'b0;
        held        = cur_acc;
      end else begin
        bus.MEM_RDY   = 1'b1;
        bus.MEM_RDATA = rd(bus.MEM_ADDR);
        check("acc_expected", acc_q.size() != 0, 1'b1);
        if (acc_q.size() != 0) begin
          exp_acc = acc_q.pop_front();
          check("access", cur_acc, exp_acc);
        end
      end
    end
  end

  task automatic drive_start(input logic [15:0] ir, input logic [15:0] ea, input logic [15:0] sr);
    bus.START   = 1'b1;
    bus.IR      = ir;
    bus.EA      = ea;
    bus.SR_DATA = sr;
    @(posedge CLK);
    #1;
    bus.START   = 1'b0;
    bus.IR      = 16'($urandom);
    bus.EA      = 16'($urandom);
    bus.SR_DATA = 16'($urandom);
  endtask

  task automatic run_op(input logic [15:0] ir, input logic [15:0] ea, input logic [15:0] sr,
                        input int waits, input bit poke_start);
    logic [3:0]  op;
    bit          ld, st, ind, lea, got;
    logic [15:0] ptr, val;
    logic [18:0] e;
    int          exp_done, c;
    op  = ir[15:12];
    ld  = (op == 4'b0010) || (op == 4'b0110) || (op == 4'b1010);
    st  = (op == 4'b0011) || (op == 4'b0111) || (op == 4'b1011);
    ind = (op == 4'b1010) || (op == 4'b1011);
    lea = (op == 4'b1110);
    ptr = ind ? rd(ea) : ea;
    if (ind) acc_q.push_back({1'b0, ea, 16'h0000});
    if (ld || st) acc_q.push_back({st, ptr, st ? sr : 16'h0000});
    if (ld) begin
      val        = rd(ptr);
      model_load = val;
      model_nzp  = nzp_of(val);
    end else if (lea) begin
      model_load = ea;
      model_nzp  = nzp_of(ea);
    end else if (st) begin
      mem[ptr] = sr;
    end
    exp_q.push_back({model_load, model_nzp});
    exp_done = lea ? 1 : (ind ? 3 + 2 * waits : 2 + waits);
    wait_n   = waits;

    drive_start(ir, ea, sr);
    c   = 0;
    got = 1'b0;
    while (!got && c < 300) begin
      @(negedge CLK);
      c++;
      if (c == 1) begin
        check("busy_c1", bus.BUSY, 1'b1);
        check("req_c1", bus.MEM_REQ, !lea);
        if (!lea) begin
          check("addr_c1", bus.MEM_ADDR, ea);
          check("we_c1", bus.MEM_WE, st && !ind);
        end
      end
      if (poke_start && c == 2) begin
        bus.START = 1'b1;
        bus.IR    = 16'h2000;
        bus.EA    = 16'h3000;
      end
      if (poke_start && c == 3) bus.START = 1'b0;
      if (bus.DONE) got = 1'b1;
    end
    check("done_seen", got, 1'b1);
    check("done_cycle", c, exp_done);
    e = exp_q.pop_front();
    check("result", {bus.LOAD_DATA, bus.N, bus.Z, bus.P}, e);
    @(negedge CLK);
    check("busy_after", bus.BUSY, 1'b0);
    check("done_after", bus.DONE, 1'b0);
    check("acc_pending", acc_q.size(), 0);
  endtask

  initial begin
    logic [3:0]  ops[4];
    logic [15:0] a;
    RESET       = 1'b1;
    bus.START   = 1'b0;
    bus.IR      = 16'h0000;
    bus.EA      = 16'h0000;
    bus.SR_DATA = 16'h0000;
    model_load  = 16'h0000;
    model_nzp   = 3'b010;
    mem[16'h3000] = 16'h8001;
    mem[16'h3010] = 16'h4000;
    mem[16'h4000] = 16'h0000;
    mem[16'h3020] = 16'h5000;
    mem[16'h3030] = 16'hFFFF;
    mem[16'hFFFF] = 16'h1357;
    for (int i = 0; i < 16; i++) mem[16'h6000 + 16'(i)] = 16'($urandom);

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy", bus.BUSY, 1'b0);
    check("rst_done", bus.DONE, 1'b0);
    check("rst_req", bus.MEM_REQ, 1'b0);
    check("rst_we", bus.MEM_WE, 1'b0);
    check("rst_addr", bus.MEM_ADDR, 16'h0000);
    check("rst_wdata", bus.MEM_WDATA, 16'h0000);
    check("rst_result", {bus.LOAD_DATA, bus.N, bus.Z, bus.P}, {16'h0000, 3'b010});
    check("rst_state", bus.dbg_state, 3'd0);
    RESET = 1'b0;
    @(negedge CLK);

    run_op(16'h2000, 16'h3000, 16'h0000, 0, 1'b0);  // LD -> 8001, N
    run_op(16'hB000, 16'h3020, 16'hBEEF, 0, 1'b0);  // STI -> write 5000, N kept
    run_op(16'hA000, 16'h3010, 16'h0000, 2, 1'b0);  // LDI, 2 waits, Z
    run_op(16'hE005, 16'h0042, 16'h0000, 0, 1'b0);  // LEA -> P
    run_op(16'hA000, 16'h3030, 16'h0000, 1, 1'b0);  // LDI through pointer FFFF
    run_op(16'h6000, 16'h5000, 16'h0000, 0, 1'b0);  // LDR reads BEEF stored by STI

    ops = '{4'b0010, 4'b0110, 4'b0011, 4'b0111};
    for (int i = 0; i < 8; i++) begin
      a = 16'h6000 + 16'($urandom_range(0, 15));
      run_op({ops[$urandom_range(0, 3)], 12'h000}, a, 16'($urandom), $urandom_range(0, 2), 1'b0);
    end

    // Illegal opcode: no state change and no outputs disturbed.
    drive_start(16'h1234, 16'h7777, 16'h5555);
    repeat (3) begin
      @(negedge CLK);
      check("ill_busy", bus.BUSY, 1'b0);
      check("ill_req", bus.MEM_REQ, 1'b0);
      check("ill_done", bus.DONE, 1'b0);
      check("ill_result", {bus.LOAD_DATA, bus.N, bus.Z, bus.P}, {model_load, model_nzp});
    end

    // START while an ST is stalled must be ignored.
    run_op(16'h3000, 16'h6100, 16'h1234, 3, 1'b1);
    repeat (4) begin
      @(negedge CLK);
      check("poke_no_done", bus.DONE, 1'b0);
      check("poke_no_req", bus.MEM_REQ, 1'b0);
    end

    // Reset during a DATA_RD wait abandons the request.
    mem[16'h6200] = 16'h0007;
    wait_n = 6;
    acc_q.push_back({1'b0, 16'h6200, 16'h0000});
    drive_start(16'h2000, 16'h6200, 16'h0000);
    repeat (3) @(negedge CLK);
    check("mid_req", bus.MEM_REQ, 1'b1);
    RESET = 1'b1;
    @(negedge CLK);
    check("rr_req", bus.MEM_REQ, 1'b0);
    check("rr_busy", bus.BUSY, 1'b0);
    check("rr_done", bus.DONE, 1'b0);
    check("rr_result", {bus.LOAD_DATA, bus.N, bus.Z, bus.P}, {16'h0000, 3'b010});
    check("rr_state", bus.dbg_state, 3'd0);
    RESET = 1'b0;
    acc_q.delete();
    model_load = 16'h0000;
    model_nzp  = 3'b010;
    @(negedge CLK);
    run_op(16'h2000, 16'h6200, 16'h0000, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
